cordic_job_scheduler: RTL and testbench
=======================================

# cordic_job_scheduler

Shares one CORDIC core among NREQ requesters. It accepts operand words over per-requester valid/ready ports, round-robin arbitrates, and issues one job per cycle to the core. Requester IDs are tracked in an in-order tag FIFO, so each result returns to the requester that issued it. It sits between the bus-side/DMA requesters and the CORDIC pipeline, and also flags orphan results and stalled jobs.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 32, operand/result width
- TIMEOUT, 1024, cycles the oldest outstanding job may wait before err_timeout sets
- HCLK  in  1  clock; all logic on rising edge
- HRESETn  in  1  synchronous active-low reset, sampled on HCLK rising edge
- req_valid  in  NREQ  requester i has an operand
- req_data  in  NREQ*DW  operand of requester i at bits [i*DW +: DW]
- req_ready  out  NREQ  grant; handshake when req_valid[i] && req_ready[i]
- rsp_valid  out  NREQ  result held for requester i
- rsp_data  out  NREQ*DW  result register of requester i
- rsp_ready  in  NREQ  requester i consumes its result
- cordic_in  out  DW  operand to core
- cordic_valid_in  out  1  one-cycle issue strobe to core
- cordic_valid_out  in  1  core result strobe; core is in-order and has no backpressure
- cordic_out  in  DW  core result, valid with cordic_valid_out
- busy  out  1  any job pending (issued, or result not yet consumed)
- err_orphan  out  1  sticky: result arrived with no outstanding tag
- err_timeout  out  1  sticky: oldest outstanding job exceeded TIMEOUT

## Operation
- Per-requester `pending[i]` register: set on request handshake; cleared on response handshake (rsp_valid[i] && rsp_ready[i]). Each requester has at most one job in flight, so the tag FIFO depth is NREQ and it can never overflow.
- Eligible(i) = req_valid[i] && !pending[i].
- Round-robin arbitration: search starts at rr_ptr and moves upward with wrap. At most one req_ready bit is high per cycle. req_ready is combinational from registered state and req_valid only.
- After granting i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds.
- Issue on grant to i:
  - cordic_in <= req_data[i]; cordic_valid_in <= 1 on the next cycle; otherwise cordic_valid_in <= 0.
  - cordic_in holds its last value when idle.
  - Tag i is pushed into the tag FIFO in the grant cycle.
- Return on cordic_valid_out:
  - Pop head tag t; rsp_data[t] <= cordic_out; rsp_valid[t] <= 1.
  - If the FIFO is empty: drop the result, set err_orphan, leave all rsp_* unchanged.
- Push and pop in the same cycle are supported; occupancy is unchanged.
- Response handshake clears rsp_valid[t] and pending[t] on the next edge.
- Watchdog:
  - Counter resets to 0 when the FIFO is empty or a pop occurs; otherwise it increments, saturating at TIMEOUT.
  - err_timeout sets when the counter reaches TIMEOUT.
  - Both error flags clear only on reset.
- busy = |pending.

## Timing
- Reset values (synchronous reset): req_ready 0, rsp_valid 0, rsp_data 0, cordic_in 0, cordic_valid_in 0, busy 0, err_orphan 0, err_timeout 0, rr_ptr 0, FIFO empty, watchdog counter 0, pending 0.
- Reset asserted mid-operation discards in-flight tags. Core results arriving afterward are orphans and set err_orphan.
- Issue latency: handshake in cycle N -> cordic_valid_in high in cycle N+1.
- Return latency: cordic_valid_out in cycle M -> rsp_valid[t] high in cycle M+1.
- Re-request timing: a requester whose response is accepted in cycle K can be granted no earlier than cycle K+1. pending is registered, so no same-cycle bypass.
- Throughput: one issue per cycle across requesters when at least NREQ-wide parallelism exists.
- A result returning to requester t while rsp_valid[t] is still set cannot occur by construction. The bench asserts that it never does.

## Test plan
- Single job: requester 0 sends 0x1234_5678; core model echoes it 5 cycles later. Required: cordic_valid_in high 1 cycle after handshake; rsp_valid[0] high 1 cycle after cordic_valid_out; rsp_data[0] = 0x1234_5678; busy falls after rsp_ready.
- Round-robin fairness: all 4 requesters hold valid continuously, with 3-cycle core latency and immediate rsp_ready. Required grant order 0,1,2,3,0,1,…; no requester is granted twice before the others get one grant each.
- Routing: requesters 2, 0, 3 issue 0xA, 0xB, 0xC in that order; the core returns 0xA+1, 0xB+1, 0xC+1 in order. Required: rsp_data[2]=0xB, rsp_data[0]=0xC, rsp_data[3]=0xD.
- Backpressure: requester 1's rsp_ready is held low for 20 cycles while req_valid[1] stays high. Required: req_ready[1]=0 throughout; requesters 0, 2, 3 continue to be served; requester 1 is regranted one cycle after its response is accepted.
- Orphan result and simultaneous push/pop:
  - Inject cordic_valid_out with the FIFO empty. Required: err_orphan=1 and no rsp_valid change.
  - Then issue in the same cycle as a pop. Required: FIFO occupancy unchanged and correct routing afterward.
- Timeout and reset: the core never returns a result. Required: err_timeout rises exactly TIMEOUT cycles after issue. Then assert HRESETn=0 for 1 cycle; required: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/cordic_job_scheduler_if.sv
// ---------------------------------------------------------------------------
// cordic_job_scheduler_if
// Bundles the requester-side and core-side handshake buses of the CORDIC
// job scheduler.
//   req_valid/req_data/req_ready : per-requester operand channel
//   rsp_valid/rsp_data/rsp_ready : per-requester result channel
//   cordic_in/cordic_valid_in    : issue port toward the CORDIC core
//   cordic_out/cordic_valid_out  : in-order result port from the core
// Modports: master = requesters + core model, slave = scheduler.
// req_data/rsp_data are packed [NREQ-1:0][DW-1:0]; lane i sits at
// bits [i*DW +: DW] of the flattened vector.
// ---------------------------------------------------------------------------
interface cordic_job_scheduler_if #(
   parameter int NREQ = 4,
   parameter int DW   = 32
);
   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0][DW-1:0] req_data;
   logic [NREQ-1:0]         req_ready;
   logic [NREQ-1:0]         rsp_valid;
   logic [NREQ-1:0][DW-1:0] rsp_data;
   logic [NREQ-1:0]         rsp_ready;
   logic [DW-1:0]           cordic_in;
   logic                    cordic_valid_in;
   logic                    cordic_valid_out;
   logic [DW-1:0]           cordic_out;

   modport master (
      output req_valid, req_data, rsp_ready, cordic_valid_out, cordic_out,
      input  req_ready, rsp_valid, rsp_data, cordic_in, cordic_valid_in
   );

   modport slave (
      input  req_valid, req_data, rsp_ready, cordic_valid_out, cordic_out,
      output req_ready, rsp_valid, rsp_data, cordic_in, cordic_valid_in
   );
endinterface

// File: rtl/cordic_job_scheduler.sv
// ---------------------------------------------------------------------------
// cordic_job_scheduler
// Shares one in-order CORDIC core among NREQ requesters. Operands are
// round-robin arbitrated and issued one per cycle; the granted requester id
// is pushed into an in-order tag FIFO so each core result is routed back to
// the requester that issued it. Also flags orphan results (no outstanding
// tag) and a stalled oldest job (watchdog).
// Ports:
//   HCLK, HRESETn : clock, synchronous active-low reset
//   bus           : cordic_job_scheduler_if.slave (requester + core buses)
//   busy          : some requester has a job issued or a result unconsumed
//   err_orphan    : sticky, core result arrived with the tag FIFO empty
//   err_timeout   : sticky, oldest outstanding job waited TIMEOUT cycles
// ---------------------------------------------------------------------------

// Per-requester slot: tracks the in-flight flag and holds the result
// register until the requester consumes it.
//   grant_i     : request handshake this cycle
//   rsp_ready_i : requester consumes its result
//   load_i      : core result for this requester arrives this cycle
//   result_i    : core result data
//   pending_o   : job issued and result not yet consumed
//   rsp_valid_o : result register holds a result
//   rsp_data_o  : result register
module cordic_job_slot #(
   parameter int DW = 32
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          grant_i,
   input  logic          rsp_ready_i,
   input  logic          load_i,
   input  logic [DW-1:0] result_i,
   output logic          pending_o,
   output logic          rsp_valid_o,
   output logic [DW-1:0] rsp_data_o
);
   logic          pending_q, pending_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic          rsp_hs;

   assign rsp_hs = rsp_valid_q & rsp_ready_i;

   // A grant and a response handshake never coincide on one slot: a slot
   // can only be granted while it has nothing pending.
   always_comb begin
      pending_d   = (pending_q | grant_i) & ~rsp_hs;
      rsp_valid_d = rsp_valid_q & ~rsp_hs;
      rsp_data_d  = rsp_data_q;
      if (load_i) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = result_i;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         pending_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         pending_q   <= pending_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign pending_o   = pending_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
endmodule

module cordic_job_scheduler #(
   parameter int NREQ    = 4,
   parameter int DW      = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   cordic_job_scheduler_if.slave  bus,
   output logic                   busy,
   output logic                   err_orphan,
   output logic                   err_timeout
);
   localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(NREQ + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);

   typedef logic [TW-1:0] tag_t;

   // Pointer increment with wrap at NREQ (NREQ need not be a power of two).
   function automatic tag_t wrap_inc(tag_t p);
      return (int'(p) == NREQ - 1) ? '0 : p + tag_t'(1);
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   tag_t                    rr_q, rr_d;
   tag_t [NREQ-1:0]         fifo_q;
   tag_t                    wr_q, wr_d;
   tag_t                    rd_q, rd_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [WW-1:0]           wd_q, wd_d;
   logic [DW-1:0]           cin_q, cin_d;
   logic                    cvld_q, cvld_d;
   logic                    orph_q, orph_d;
   logic                    tmo_q, tmo_d;

   logic [NREQ-1:0]         pending;
   logic [NREQ-1:0]         rsp_valid;
   logic [NREQ-1:0][DW-1:0] rsp_data;
   logic [NREQ-1:0]         load;

   // ------------------------------------------------------------------
   // Round-robin arbiter: scan upward from rr_q with wrap, first eligible
   // requester wins. Purely a function of registered state and req_valid.
   // ------------------------------------------------------------------
   logic [NREQ-1:0] eligible, grant;
   logic            gnt_any;
   tag_t            gnt_idx;

   assign eligible = bus.req_valid & ~pending;

   always_comb begin
      tag_t idx;
      grant   = '0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      idx     = rr_q;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_any && eligible[idx]) begin
            gnt_any    = 1'b1;
            gnt_idx    = idx;
            grant[idx] = 1'b1;
         end
         idx = wrap_inc(idx);
      end
   end

   assign rr_d = gnt_any ? wrap_inc(gnt_idx) : rr_q;

   // ------------------------------------------------------------------
   // Tag FIFO. Each requester has at most one job in flight, so NREQ
   // entries always suffice. A result with the FIFO empty has no owner:
   // it is dropped and flagged. No empty-FIFO bypass for a same-cycle push.
   // ------------------------------------------------------------------
   logic fifo_empty, push, pop;
   tag_t head;

   assign fifo_empty = (cnt_q == '0);
   assign push       = gnt_any;
   assign pop        = bus.cordic_valid_out && !fifo_empty;
   assign head       = fifo_q[rd_q];
   assign wr_d       = push ? wrap_inc(wr_q) : wr_q;
   assign rd_d       = pop  ? wrap_inc(rd_q) : rd_q;

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + CW'(1);
      else if (pop && !push)
         cnt_d = cnt_q - CW'(1);
   end

   // ------------------------------------------------------------------
   // Watchdog on the oldest outstanding job: restarts whenever the head
   // retires or nothing is outstanding, saturates at TIMEOUT.
   // ------------------------------------------------------------------
   always_comb begin
      wd_d = wd_q;
      if (fifo_empty || pop)
         wd_d = '0;
      else if (wd_q != WD_MAX)
         wd_d = wd_q + WW'(1);
   end

   assign orph_d = orph_q | (bus.cordic_valid_out && fifo_empty);
   assign tmo_d  = tmo_q  | (wd_d == WD_MAX);

   // Issue register: operand captured in the grant cycle, strobe one cycle
   // later; the operand is left stale while idle.
   assign cin_d  = gnt_any ? bus.req_data[gnt_idx] : cin_q;
   assign cvld_d = gnt_any;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         rr_q   <= '0;
         fifo_q <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         wd_q   <= '0;
         cin_q  <= '0;
         cvld_q <= 1'b0;
         orph_q <= 1'b0;
         tmo_q  <= 1'b0;
      end else begin
         rr_q   <= rr_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         wd_q   <= wd_d;
         cin_q  <= cin_d;
         cvld_q <= cvld_d;
         orph_q <= orph_d;
         tmo_q  <= tmo_d;
         if (push)
            fifo_q[wr_q] <= gnt_idx;
      end
   end

   // ------------------------------------------------------------------
   // Per-requester slots
   // ------------------------------------------------------------------
   for (genvar i = 0; i < NREQ; i++) begin : g_slot
      assign load[i] = pop && (head == tag_t'(i));

      cordic_job_slot #(.DW(DW)) u_slot (
         .HCLK        (HCLK),
         .HRESETn     (HRESETn),
         .grant_i     (grant[i]),
         .rsp_ready_i (bus.rsp_ready[i]),
         .load_i      (load[i]),
         .result_i    (bus.cordic_out),
         .pending_o   (pending[i]),
         .rsp_valid_o (rsp_valid[i]),
         .rsp_data_o  (rsp_data[i])
      );
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.req_ready       = grant;
   assign bus.rsp_valid       = rsp_valid;
   assign bus.rsp_data        = rsp_data;
   assign bus.cordic_in       = cin_q;
   assign bus.cordic_valid_in = cvld_q;
   assign busy                = |pending;
   assign err_orphan          = orph_q;
   assign err_timeout         = tmo_q;
endmodule

// File: tb/tb_cordic_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cordic_job_scheduler
// Self-checking bench for cordic_job_scheduler. A core model inside tick()
// returns results after core_lat cycles (echo or +1). Every request
// handshake pushes {requester, expected result} to a scoreboard queue; every
// newly delivered rsp_valid pops and compares it.
// ---------------------------------------------------------------------------
module tb_cordic_job_scheduler;
   localparam int NREQ    = 4;
   localparam int DW      = 32;
   localparam int TIMEOUT = 40;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;
   logic busy, err_orphan, err_timeout;

   always #5 HCLK = ~HCLK;

   cordic_job_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

   cordic_job_scheduler #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .bus         (bus),
      .busy        (busy),
      .err_orphan  (err_orphan),
      .err_timeout (err_timeout)
   );

   typedef struct { int id; logic [DW-1:0] data; } sb_t;
   typedef struct { int unsigned due; logic [DW-1:0] data; } core_t;

   sb_t             sb[$];
   core_t           core_q[$];
   int              glog[$];
   logic [NREQ-1:0] seen = '0;
   int              nvec = 0;
   int              nerr = 0;
   int unsigned     cyc = 0;
   int unsigned     core_lat = 3;
   bit              core_inc = 1'b0;
   bit              core_drop = 1'b0;

   // One clock cycle: observe handshakes of the ending cycle, cross the
   // edge, then advance the core model.
   task automatic tick();
      sb_t   ent;
      core_t ce;
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (bus.rsp_valid[i] === 1'b1 && !seen[i]) begin
            nvec++;
            if (sb.size() == 0) begin
               nerr++;
               $display("FAIL rsp_route: unexpected result %h on requester %0d", bus.rsp_data[i], i);
            end else begin
               ent = sb.pop_front();
               if (ent.id !== i || bus.rsp_data[i] !== ent.data) begin
                  nerr++;
                  $display("FAIL rsp_route: requester %0d data %h, want requester %0d data %h",
                           i, bus.rsp_data[i], ent.id, ent.data);
               end
            end
            seen[i] = 1'b1;
         end
         if (bus.rsp_valid[i] === 1'b1 && bus.rsp_ready[i]) seen[i] = 1'b0;
      end
      nvec++;
      if ($countones(bus.req_ready) > 1) begin
         nerr++;
         $display("FAIL one_hot_grant: req_ready %b, want at most one bit", bus.req_ready);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (bus.req_valid[i] && bus.req_ready[i] === 1'b1) begin
            ent.id   = i;
            ent.data = core_inc ? bus.req_data[i] + 1 : bus.req_data[i];
            sb.push_back(ent);
            glog.push_back(i);
         end
      end
      if (bus.cordic_valid_out && sb.size() > 0) begin
         nvec++;
         if (bus.rsp_valid[sb[0].id] !== 1'b0) begin
            nerr++;
            $display("FAIL rsp_overwrite: result for requester %0d while rsp_valid %b", sb[0].id, bus.rsp_valid);
         end
      end
      @(posedge HCLK);
      #1;
      cyc++;
      if (bus.cordic_valid_in === 1'b1 && !core_drop) begin
         ce.due  = cyc + core_lat;
         ce.data = core_inc ? bus.cordic_in + 1 : bus.cordic_in;
         core_q.push_back(ce);
      end
      bus.cordic_valid_out = 1'b0;
      if (core_q.size() > 0 && core_q[0].due == cyc) begin
         ce = core_q.pop_front();
         bus.cordic_valid_out = 1'b1;
         bus.cordic_out       = ce.data;
      end
   endtask

   task automatic do_reset();
      bus.req_valid = '0;
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1;
      sb.delete();
      core_q.delete();
      glog.delete();
      seen = '0;
   endtask

   task automatic drain();
      bus.req_valid = '0;
      bus.rsp_ready = '1;
      for (int k = 0; k < 60 && (busy !== 1'b0 || sb.size() > 0); k++) tick();
      nvec++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         nerr++;
         $display("FAIL drain: busy %b outstanding %0d, want 0 0", busy, sb.size());
      end
      bus.rsp_ready = '0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      tick();
      tick();
      nvec++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.cordic_in, bus.cordic_valid_in,
           busy, err_orphan, err_timeout} !== '0) begin
         nerr++;
         $display("FAIL reset_state: rdy %b rv %b cin %h cv %b busy %b eo %b et %b, want all 0",
                  bus.req_ready, bus.rsp_valid, bus.cordic_in, bus.cordic_valid_in, busy, err_orphan, err_timeout);
      end
      HRESETn = 1'b1;
      tick();
   endtask

   task automatic test_single_job();
      bit found = 1'b0;
      int lat = 0;
      core_lat = 5;
      core_inc = 1'b0;
      bus.req_data[0]  = 32'h1234_5678;
      bus.req_valid[0] = 1'b1;
      #1;
      nvec++;
      if (bus.req_ready !== 4'b0001) begin
         nerr++;
         $display("FAIL single_grant: req_ready %b, want 0001", bus.req_ready);
      end
      tick();
      bus.req_valid[0] = 1'b0;
      nvec++;
      if (bus.cordic_valid_in !== 1'b1 || bus.cordic_in !== 32'h1234_5678) begin
         nerr++;
         $display("FAIL issue_latency: valid_in %b in %h, want 1 12345678", bus.cordic_valid_in, bus.cordic_in);
      end
      for (int k = 1; k <= 20 && !found; k++) begin
         tick();
         if (bus.cordic_valid_out) begin
            found = 1'b1;
            lat   = k;
         end
      end
      nvec++;
      if (!found || lat != 5) begin
         nerr++;
         $display("FAIL core_latency: found %0d after %0d cycles, want 5", found, lat);
      end
      tick();
      nvec++;
      if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0] !== 32'h1234_5678 || busy !== 1'b1) begin
         nerr++;
         $display("FAIL return_latency: rsp_valid %b data %h busy %b, want 1 12345678 1",
                  bus.rsp_valid[0], bus.rsp_data[0], busy);
      end
      bus.rsp_ready[0] = 1'b1;
      tick();
      bus.rsp_ready[0] = 1'b0;
      nvec++;
      if (busy !== 1'b0 || bus.rsp_valid[0] !== 1'b0) begin
         nerr++;
         $display("FAIL busy_clear: busy %b rsp_valid %b, want 0 0", busy, bus.rsp_valid[0]);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      core_lat = 3;
      core_inc = 1'b0;
      bus.rsp_ready = '1;
      bus.req_valid = '1;
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < NREQ; i++) bus.req_data[i] = $urandom();
         tick();
      end
      nvec++;
      if (glog.size() < 16) begin
         nerr++;
         $display("FAIL rr_count: %0d grants, want at least 16", glog.size());
      end
      foreach (glog[k]) begin
         nvec++;
         if (glog[k] != k % NREQ) begin
            nerr++;
            $display("FAIL rr_order: grant %0d went to %0d, want %0d", k, glog[k], k % NREQ);
         end
      end
      drain();
   endtask

   task automatic test_routing();
      int          ids[3]  = '{2, 0, 3};
      logic [31:0] ops[3]  = '{32'hA, 32'hB, 32'hC};
      core_lat = 3;
      core_inc = 1'b1;
      bus.rsp_ready = '0;
      for (int j = 0; j < 3; j++) begin
         bus.req_data[ids[j]]  = ops[j];
         bus.req_valid[ids[j]] = 1'b1;
         tick();
         bus.req_valid[ids[j]] = 1'b0;
      end
      for (int k = 0; k < 10; k++) tick();
      nvec++;
      if (bus.rsp_valid !== 4'b1101 || bus.rsp_data[2] !== 32'hB ||
          bus.rsp_data[0] !== 32'hC || bus.rsp_data[3] !== 32'hD) begin
         nerr++;
         $display("FAIL routing: rv %b d2 %h d0 %h d3 %h, want 1101 b c d",
                  bus.rsp_valid, bus.rsp_data[2], bus.rsp_data[0], bus.rsp_data[3]);
      end
      drain();
      core_inc = 1'b0;
   endtask

   task automatic test_backpressure();
      bit got1 = 1'b0;
      int gcnt[NREQ];
      core_lat = 3;
      bus.rsp_ready = 4'b1101;
      bus.req_valid = '1;
      for (int k = 0; k < 30 && !got1; k++) begin
         for (int i = 0; i < NREQ; i++) bus.req_data[i] = $urandom();
         #1;
         if (bus.req_ready[1] === 1'b1) got1 = 1'b1;
         tick();
      end
      nvec++;
      if (!got1) begin
         nerr++;
         $display("FAIL bp_first_grant: requester 1 never granted, want granted");
      end
      foreach (gcnt[i]) gcnt[i] = 0;
      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < NREQ; i++) bus.req_data[i] = $urandom();
         #1;
         nvec++;
         if (bus.req_ready[1] !== 1'b0) begin
            nerr++;
            $display("FAIL bp_hold: cycle %0d req_ready[1] %b, want 0", k, bus.req_ready[1]);
         end
         for (int i = 0; i < NREQ; i++) if (bus.req_ready[i] === 1'b1) gcnt[i]++;
         tick();
      end
      for (int i = 0; i < NREQ; i++) begin
         if (i == 1) continue;
         nvec++;
         if (gcnt[i] < 3) begin
            nerr++;
            $display("FAIL bp_others: requester %0d got %0d grants, want at least 3", i, gcnt[i]);
         end
      end
      nvec++;
      if (bus.rsp_valid[1] !== 1'b1) begin
         nerr++;
         $display("FAIL bp_rsp_held: rsp_valid[1] %b, want 1", bus.rsp_valid[1]);
      end
      bus.rsp_ready[1] = 1'b1;
      bus.req_valid    = 4'b0010;
      #1;
      nvec++;
      if (bus.req_ready[1] !== 1'b0) begin
         nerr++;
         $display("FAIL bp_no_bypass: req_ready[1] %b in accept cycle, want 0", bus.req_ready[1]);
      end
      tick();
      bus.rsp_ready[1] = 1'b0;
      #1;
      nvec++;
      if (bus.req_ready[1] !== 1'b1) begin
         nerr++;
         $display("FAIL bp_regrant: req_ready[1] %b one cycle after accept, want 1", bus.req_ready[1]);
      end
      tick();
      drain();
   endtask

   task automatic test_orphan_pushpop();
      logic [NREQ-1:0]         v_snap;
      logic [NREQ-1:0][DW-1:0] d_snap;
      bit found = 1'b0;
      nvec++;
      if (err_orphan !== 1'b0) begin
         nerr++;
         $display("FAIL orphan_pre: err_orphan %b, want 0", err_orphan);
      end
      v_snap = bus.rsp_valid;
      d_snap = bus.rsp_data;
      bus.cordic_valid_out = 1'b1;
      bus.cordic_out       = 32'hDEAD_BEEF;
      tick();
      nvec++;
      if (err_orphan !== 1'b1 || bus.rsp_valid !== v_snap || bus.rsp_data !== d_snap) begin
         nerr++;
         $display("FAIL orphan: err_orphan %b rv %b, want 1 %b (data unchanged)", err_orphan, bus.rsp_valid, v_snap);
      end
      core_lat = 2;
      bus.req_data[0]  = 32'h100;
      bus.req_valid[0] = 1'b1;
      tick();
      bus.req_valid[0] = 1'b0;
      tick();
      tick();
      bus.req_data[2]  = 32'h200;
      bus.req_valid[2] = 1'b1;
      #1;
      nvec++;
      if (bus.req_ready[2] !== 1'b1 || bus.cordic_valid_out !== 1'b1) begin
         nerr++;
         $display("FAIL pushpop_align: req_ready[2] %b valid_out %b, want 1 1", bus.req_ready[2], bus.cordic_valid_out);
      end
      tick();
      bus.req_valid[2] = 1'b0;
      nvec++;
      if (dut.cnt_q !== 3'd1 || bus.rsp_valid[0] !== 1'b1) begin
         nerr++;
         $display("FAIL pushpop_occupancy: occupancy %0d rsp_valid[0] %b, want 1 1", dut.cnt_q, bus.rsp_valid[0]);
      end
      for (int k = 0; k < 10 && !found; k++) begin
         tick();
         if (bus.rsp_valid[2] === 1'b1) found = 1'b1;
      end
      nvec++;
      if (!found || bus.rsp_data[2] !== 32'h200 || bus.rsp_data[0] !== 32'h100) begin
         nerr++;
         $display("FAIL pushpop_route: found %0d d2 %h d0 %h, want 1 200 100", found, bus.rsp_data[2], bus.rsp_data[0]);
      end
      drain();
   endtask

   task automatic test_timeout_reset();
      bit found = 1'b0;
      int lat = 0;
      core_drop = 1'b1;
      bus.req_data[1]  = 32'h5555;
      bus.req_valid[1] = 1'b1;
      tick();
      bus.req_valid[1] = 1'b0;
      nvec++;
      if (bus.cordic_valid_in !== 1'b1 || err_timeout !== 1'b0) begin
         nerr++;
         $display("FAIL timeout_issue: valid_in %b err_timeout %b, want 1 0", bus.cordic_valid_in, err_timeout);
      end
      for (int k = 1; k <= TIMEOUT + 20 && !found; k++) begin
         tick();
         if (err_timeout === 1'b1) begin
            found = 1'b1;
            lat   = k;
         end
      end
      nvec++;
      if (!found || lat != TIMEOUT) begin
         nerr++;
         $display("FAIL timeout: found %0d after %0d cycles, want %0d", found, lat, TIMEOUT);
      end
      nvec++;
      if (busy !== 1'b1 || err_orphan !== 1'b1) begin
         nerr++;
         $display("FAIL timeout_state: busy %b err_orphan %b, want 1 1", busy, err_orphan);
      end
      HRESETn = 1'b0;
      tick();
      nvec++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.cordic_in, bus.cordic_valid_in,
           busy, err_orphan, err_timeout} !== '0) begin
         nerr++;
         $display("FAIL midrun_reset: rv %b cin %h cv %b busy %b eo %b et %b, want all 0",
                  bus.rsp_valid, bus.cordic_in, bus.cordic_valid_in, busy, err_orphan, err_timeout);
      end
      HRESETn = 1'b1;
      sb.delete();
      core_q.delete();
      seen = '0;
      core_drop = 1'b0;
      bus.cordic_valid_out = 1'b1;
      bus.cordic_out       = 32'hCAFE;
      tick();
      nvec++;
      if (err_orphan !== 1'b1 || bus.rsp_valid !== '0) begin
         nerr++;
         $display("FAIL late_orphan: err_orphan %b rv %b, want 1 0000", err_orphan, bus.rsp_valid);
      end
   endtask

   initial begin
      bus.req_valid        = '0;
      bus.req_data         = '0;
      bus.rsp_ready        = '0;
      bus.cordic_valid_out = 1'b0;
      bus.cordic_out       = '0;
      test_reset();
      test_single_job();
      test_round_robin();
      test_routing();
      test_backpressure();
      test_orphan_pushpop();
      test_timeout_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
